// File: rtl/ram_arbiter_6502.sv
// Shares a single-port RAM between the 6502 core bus (one access per rising
// clk2out edge) and one external req/ack requester, all timed on eclk.
module ram_arbiter_6502 #(
   parameter int AW     = 16,
   parameter int DW     = 8,
   parameter int RD_LAT = 1
) (
   input  logic          eclk,
   input  logic          ereset,
   input  logic          cpu_clk2,
   input  logic [AW-1:0] cpu_ab,
   input  logic [DW-1:0] cpu_db_o,
   input  logic          cpu_rw,
   output logic [DW-1:0] cpu_db_i,
   input  logic          ext_req,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_wdata,
   output logic          ext_ack,
   output logic [DW-1:0] ext_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          cpu_overrun,
   output logic [7:0]    overrun_cnt
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_CPU_ACC  = 3'd1;
   localparam logic [2:0] ST_CPU_WAIT = 3'd2;
   localparam logic [2:0] ST_EXT_ACC  = 3'd3;
   localparam logic [2:0] ST_EXT_WAIT = 3'd4;
   localparam logic [2:0] ST_EXT_DONE = 3'd5;

   logic [2:0] state;
   logic [2:0] lat_cnt;
   logic       clk2_q;
   logic       cpu_pend;
   logic       acc_we;
   logic       clk2_edge;
   logic       cpu_grant;
   logic       ext_grant;
   logic       rd_done;

   assign clk2_edge = cpu_clk2 & ~clk2_q;
   assign rd_done   = (lat_cnt == 3'd1);

   // CPU wins any tie; the external port is only sampled from IDLE.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
      cpu_grant = 1'b0;
      ext_grant = 1'b0;
      if (state == ST_IDLE) begin
         if (cpu_pend || clk2_edge) cpu_grant = 1'b1;
         else if (ext_req)          ext_grant = 1'b1;
      end
   end

   always_ff @(posedge eclk) begin
      if (ereset) begin
         // NOTE: clk2_q tracks the live input during reset so a clk2 held high is not seen as an edge on release.
         clk2_q      <= cpu_clk2;
         state       <= ST_IDLE;
         lat_cnt     <= 3'd0;
         cpu_pend    <= 1'b0;
         acc_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_we      <= 1'b0;
         cpu_db_i    <= '0;
         ext_ack     <= 1'b0;
         ext_rdata   <= '0;
         cpu_overrun <= 1'b0;
         overrun_cnt <= 8'd0;
      end else begin
         clk2_q  <= cpu_clk2;
         mem_we  <= 1'b0;
         ext_ack <= 1'b0;

         if (clk2_edge && cpu_pend) begin
            cpu_overrun <= 1'b1;
            if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
         end
         // NOTE: the grant below assigns cpu_pend again later in this block; the last nonblocking assignment wins.
         if (clk2_edge) cpu_pend <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (cpu_grant) begin
                  cpu_pend <= 1'b0;
                  mem_addr <= cpu_ab;
                  mem_we   <= ~cpu_rw;
                  acc_we   <= ~cpu_rw;
                  if (!cpu_rw) mem_wdata <= cpu_db_o;
                  state    <= ST_CPU_ACC;
               end else if (ext_grant) begin
                  mem_addr <= ext_addr;
                  mem_we   <= ext_we;
                  acc_we   <= ext_we;
                  if (ext_we) mem_wdata <= ext_wdata;
                  state    <= ST_EXT_ACC;
               end
            end
            ST_CPU_ACC: begin
               if (acc_we) begin
                  state <= ST_IDLE;
               end else begin
                  lat_cnt <= 3'(RD_LAT);
                  state   <= ST_CPU_WAIT;
               end
            end
            ST_CPU_WAIT: begin
               lat_cnt <= lat_cnt - 3'd1;
               if (rd_done) begin
                  cpu_db_i <= mem_rdata;
                  state    <= ST_IDLE;
               end
            end
            ST_EXT_ACC: begin
               if (acc_we) begin
                  ext_ack <= 1'b1;
                  state   <= ST_EXT_DONE;
               end else begin
                  lat_cnt <= 3'(RD_LAT);
                  state   <= ST_EXT_WAIT;
               end
            end
            ST_EXT_WAIT: begin
               lat_cnt <= lat_cnt - 3'd1;
               if (rd_done) begin
                  ext_rdata <= mem_rdata;
                  ext_ack   <= 1'b1;
                  state     <= ST_EXT_DONE;
               end
            end
            ST_EXT_DONE: state <= ST_IDLE;
            default:     state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter_6502.sv
// Bench for ram_arbiter_6502: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of arbitration and latency.
module tb_ram_arbiter_6502;

   localparam int AW     = 16;
   localparam int DW     = 8;
   localparam int RD_LAT = 3;
   localparam int NS     = 16;

   logic          eclk = 1'b0;
   logic          ereset;
   logic          cpu_clk2;
   logic [AW-1:0] cpu_ab;
   logic [DW-1:0] cpu_db_o;
   logic          cpu_rw;
   logic [DW-1:0] cpu_db_i;
   logic          ext_req;
   logic          ext_we;
   logic [AW-1:0] ext_addr;
   logic [DW-1:0] ext_wdata;
   logic          ext_ack;
   logic [DW-1:0] ext_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_rdata;
   logic          cpu_overrun;
   logic [7:0]    overrun_cnt;

   always #5 eclk = ~eclk;

   ram_arbiter_6502 #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .eclk(eclk), .ereset(ereset), .cpu_clk2(cpu_clk2), .cpu_ab(cpu_ab),
      .cpu_db_o(cpu_db_o), .cpu_rw(cpu_rw), .cpu_db_i(cpu_db_i),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
      .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .cpu_overrun(cpu_overrun), .overrun_cnt(overrun_cnt)
   );

   // RAM with RD_LAT cycles from address-present to data-valid
   logic [DW-1:0] ram     [0:65535];
   logic [DW-1:0] rd_pipe [0:RD_LAT-1];
   always @(posedge eclk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      rd_pipe[0] <= ram[mem_addr];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[RD_LAT-1];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, want, cyc);
      end
   endtask

   // Reference model: one transaction at a time, arbiter free again at free_at
   logic [DW-1:0] ref_mem [0:65535];
   int            free_at = 0;
   bit            m_pend = 0;
   logic          m_clk2_q = 1'b0;
   bit            m_ovr = 0;
   logic [7:0]    m_ovr_cnt = 8'd0;
   logic [DW-1:0] exp_cpu_db = '0;
   logic [DW-1:0] exp_ext_rd = '0;
   bit            rst_chk = 0;

   bit            ev_we      [NS];
   bit            ev_ack     [NS];
   bit            ev_acc     [NS];
   logic [AW-1:0] ev_addr    [NS];
   logic [DW-1:0] ev_wdata   [NS];
   bit            ev_cpu_upd [NS];
   logic [DW-1:0] ev_cpu_val [NS];
   bit            ev_ext_upd [NS];
   logic [DW-1:0] ev_ext_val [NS];

   task automatic clear_slot(input int s);
      ev_we[s] = 0; ev_ack[s] = 0; ev_acc[s] = 0; ev_cpu_upd[s] = 0; ev_ext_upd[s] = 0;
   endtask

   // One eclk cycle: model consumes this cycle's inputs, then the DUT is checked in the next cycle
   task automatic step();
      bit edge_now;
      int s;
      int s2;
      edge_now = cpu_clk2 && !m_clk2_q;
      m_clk2_q = cpu_clk2;
      if (ereset) begin
         for (int i = 0; i < NS; i++) clear_slot(i);
         m_pend = 0; m_ovr = 0; m_ovr_cnt = 8'd0;
         exp_cpu_db = '0; exp_ext_rd = '0;
         free_at = cyc + 1;
         rst_chk = 1;
      end else begin
         if (edge_now && m_pend) begin
            m_ovr = 1;
            if (m_ovr_cnt != 8'hFF) m_ovr_cnt = m_ovr_cnt + 8'd1;
         end
         s = (cyc + 1) % NS;
         if (cyc >= free_at && (m_pend || edge_now)) begin
            m_pend = 0;
            ev_acc[s] = 1; ev_addr[s] = cpu_ab;
            if (!cpu_rw) begin
               ev_we[s] = 1; ev_wdata[s] = cpu_db_o;
               ref_mem[cpu_ab] = cpu_db_o;
               free_at = cyc + 2;
            end else begin
               s2 = (cyc + 2 + RD_LAT) % NS;
               ev_cpu_upd[s2] = 1; ev_cpu_val[s2] = ref_mem[cpu_ab];
               free_at = cyc + 2 + RD_LAT;
            end
         end else if (cyc >= free_at && ext_req) begin
            ev_acc[s] = 1; ev_addr[s] = ext_addr;
            if (ext_we) begin
               ev_we[s] = 1; ev_wdata[s] = ext_wdata;
               ref_mem[ext_addr] = ext_wdata;
               ev_ack[(cyc + 2) % NS] = 1;
               free_at = cyc + 3;
            end else begin
               s2 = (cyc + 2 + RD_LAT) % NS;
               ev_ack[s2] = 1; ev_ext_upd[s2] = 1; ev_ext_val[s2] = ref_mem[ext_addr];
               free_at = cyc + 3 + RD_LAT;
            end
         end else if (edge_now) begin
            m_pend = 1;
         end
      end

      @(negedge eclk);
      cyc++;
      s = cyc % NS;
      if (ev_cpu_upd[s]) exp_cpu_db = ev_cpu_val[s];
      if (ev_ext_upd[s]) exp_ext_rd = ev_ext_val[s];
      check("mem_we", mem_we, ev_we[s]);
      check("ext_ack", ext_ack, ev_ack[s]);
      check("cpu_db_i", cpu_db_i, exp_cpu_db);
      check("ext_rdata", ext_rdata, exp_ext_rd);
      check("cpu_overrun", cpu_overrun, m_ovr);
      check("overrun_cnt", overrun_cnt, m_ovr_cnt);
      if (ev_acc[s]) begin
         check("mem_addr", mem_addr, ev_addr[s]);
         if (ev_we[s]) check("mem_wdata", mem_wdata, ev_wdata[s]);
      end
      if (rst_chk) begin
         check("rst_mem_addr", mem_addr, '0);
         check("rst_mem_wdata", mem_wdata, '0);
         rst_chk = 0;
      end
      clear_slot(s);
   endtask

   task automatic settle(input int n);
      repeat (n) step();
   endtask

   task automatic ext_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          output int lat);
      ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = data;
      lat = 0;
      do begin
         step();
         lat++;
      end while (!ext_ack && lat < 64);
      check("ext_ack_seen", ext_ack, 1'b1);
      ext_req = 1'b0;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      logic [3:0] lo;
      lo = 4'($urandom_range(0, 15));
      return {12'h020, lo};
   endfunction

   initial begin
      int lat;
      int hold;
      ereset = 1'b1; cpu_clk2 = 1'b1; cpu_ab = 16'h1234; cpu_db_o = '0; cpu_rw = 1'b1;
      ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
      @(negedge eclk);
      settle(3);

      // Release with clk2 held high: no access may start
      ereset = 1'b0;
      repeat (10) begin
         step();
         check("no_spurious_addr", mem_addr, '0);
      end
      check("rst_cpu_db", cpu_db_i, '0);
      check("rst_ext_ack", ext_ack, 1'b0);
      cpu_clk2 = 1'b0;
      settle(2);

      // Reset vector written from the external port, then fetched by the CPU
      ext_txn(1'b1, 16'hFFFC, 8'h34, lat);
      check("ext_wr_lat", lat, 2);
      settle(2);
      cpu_rw = 1'b1; cpu_ab = 16'hFFFC; cpu_clk2 = 1'b1;
      step();
      check("cpu_rd_addr", mem_addr, 16'hFFFC);
      settle(RD_LAT + 1);
      check("cpu_rd_data", cpu_db_i, 8'h34);
      cpu_clk2 = 1'b0;
      settle(3);

      ext_txn(1'b1, 16'h0200, 8'hA5, lat);
      check("ext_wr_lat2", lat, 2);
      step();
      for (int a = 1; a < 16; a++) begin
         ext_txn(1'b1, {12'h020, 4'(a)}, 8'($urandom_range(0, 255)), lat);
         step();
      end
      cpu_rw = 1'b1; cpu_ab = 16'h0200; cpu_clk2 = 1'b1;
      settle(2 + RD_LAT);
      check("cpu_rd_a5", cpu_db_i, 8'hA5);
      cpu_clk2 = 1'b0;
      settle(3);

      ext_txn(1'b0, 16'h0200, 8'h00, lat);
      check("ext_rd_lat", lat, 2 + RD_LAT);
      check("ext_rd_data", ext_rdata, 8'hA5);
      settle(3);

      // Same-cycle clk2 edge and ext read: CPU first, ext delayed by RD_LAT+2
      cpu_rw = 1'b1; cpu_ab = 16'h0201; cpu_clk2 = 1'b1;
      ext_txn(1'b0, 16'h0200, 8'h00, lat);
      check("coll_lat", lat, 4 + 2 * RD_LAT);
      check("coll_rdata", ext_rdata, 8'hA5);
      cpu_clk2 = 1'b0;
      settle(3);

      // clk2 edge during an ext read wait is served straight after EXT_DONE
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0203;
      step(); step();
      lat = 2;
      cpu_rw = 1'b1; cpu_ab = 16'h0205; cpu_clk2 = 1'b1;
      while (!ext_ack && lat < 64) begin
         step();
         lat++;
      end
      check("edge_ext_lat", lat, 2 + RD_LAT);
      ext_req = 1'b0;
      step(); step();
      check("pend_addr", mem_addr, 16'h0205);
      check("pend_no_ovr", cpu_overrun, 1'b0);
      cpu_clk2 = 1'b0;
      settle(RD_LAT + 3);

      // Back-to-back ext reads with clk2 toggling every 2 cycles drive overruns to saturation
      cpu_rw = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         if (i % 2 == 0) begin
            cpu_clk2 = ~cpu_clk2;
            if (cpu_clk2) cpu_ab = rand_addr();
         end
         if (ext_ack || !ext_req) begin
            ext_req = 1'b1; ext_we = 1'b0; ext_addr = rand_addr();
         end
         step();
      end
      check("ovr_sat_cnt", overrun_cnt, 8'hFF);
      check("ovr_sat_flag", cpu_overrun, 1'b1);
      ext_req = 1'b0;
      ereset = 1'b1;
      step();
      ereset = 1'b0;
      step();
      check("ovr_clr_cnt", overrun_cnt, 8'h00);
      check("ovr_clr_flag", cpu_overrun, 1'b0);
      settle(2);

      // Random mixed traffic
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            cpu_clk2 = ~cpu_clk2;
            hold = $urandom_range(1, 6);
            if (cpu_clk2) begin
               cpu_rw   = 1'($urandom_range(0, 1));
               cpu_ab   = rand_addr();
               cpu_db_o = 8'($urandom_range(0, 255));
            end
         end else begin
            hold--;
         end
         if (ext_ack || (!ext_req && $urandom_range(0, 3) == 0)) begin
            ext_req   = 1'($urandom_range(0, 1)) | ~ext_ack;
            ext_we    = 1'($urandom_range(0, 1));
            ext_addr  = rand_addr();
            ext_wdata = 8'($urandom_range(0, 255));
         end
         step();
      end
      cpu_clk2 = 1'b0; ext_req = 1'b0;
      settle(RD_LAT + 8);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
